// File: rtl/serial_fifo_bridge_pkg.sv
// rtl/serial_fifo_bridge_pkg.sv - shared defaults and width helper for serial_fifo_bridge
package serial_fifo_bridge_pkg;

  localparam int DATA_W_DEF     = 8;
  localparam int DEPTH_LOG2_DEF = 4;

  // Occupancy needs one extra bit so that "full" (2^DEPTH_LOG2) is representable.
  function automatic int count_w(input int depth_log2);
    return depth_log2 + 1;
  endfunction

endpackage

// File: rtl/serial_fifo_bridge_byte_fifo.sv
// rtl/serial_fifo_bridge_byte_fifo.sv - first-word-fall-through synchronous byte FIFO
//
// Ports:
//   clock, reset       clock; asynchronous active-low reset
//   push, push_data    write request and byte (refused when full)
//   pop                read request (ignored when empty)
//   pop_data           head entry, valid whenever empty == 0
//   full, empty, count occupancy status, all derived from the count register
module byte_fifo
  import serial_fifo_bridge_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           push,
  input  logic [DATA_W-1:0]              push_data,
  input  logic                           pop,
  output logic [DATA_W-1:0]              pop_data,
  output logic                           full,
  output logic                           empty,
  output logic [count_w(DEPTH_LOG2)-1:0] count
);

  localparam int CNT_W = count_w(DEPTH_LOG2);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  push_ok;
  logic                  pop_ok;

  // full/empty come straight from the count register, so ready never
  // depends combinationally on a same-cycle pop.
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // FWFT: head is always presented; no bypass from push_data.
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/serial_fifo_bridge.sv
// rtl/serial_fifo_bridge.sv - buffered bridge between processor serial pins and a byte-stream host
//
// Ports:
//   clock, reset                               clock; asynchronous active-low reset
//   proc_rx_data/valid, proc_rx_rden           RX FIFO head toward processor, pop
//   proc_tx_data, proc_tx_wren, proc_tx_ready  processor writes into TX FIFO
//   host_rx_data/valid, host_rx_ready          host writes into RX FIFO
//   host_tx_data/valid, host_tx_ready          TX FIFO head toward host, accept
//   rx_count, tx_count                         FIFO occupancies
//   err_rx_underflow, err_tx_overflow          sticky processor-side protocol errors
//   err_clear                                  clears both sticky flags
module serial_fifo_bridge
  import serial_fifo_bridge_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                           clock,
  input  logic                           reset,
  output logic [DATA_W-1:0]              proc_rx_data,
  output logic                           proc_rx_valid,
  input  logic                           proc_rx_rden,
  input  logic [DATA_W-1:0]              proc_tx_data,
  input  logic                           proc_tx_wren,
  output logic                           proc_tx_ready,
  input  logic [DATA_W-1:0]              host_rx_data,
  input  logic                           host_rx_valid,
  output logic                           host_rx_ready,
  output logic [DATA_W-1:0]              host_tx_data,
  output logic                           host_tx_valid,
  input  logic                           host_tx_ready,
  output logic [count_w(DEPTH_LOG2)-1:0] rx_count,
  output logic [count_w(DEPTH_LOG2)-1:0] tx_count,
  output logic                           err_rx_underflow,
  output logic                           err_tx_overflow,
  input  logic                           err_clear
);

  logic rx_full;
  logic rx_empty;
  logic tx_full;
  logic tx_empty;

  byte_fifo #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) rx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (host_rx_valid),
    .push_data (host_rx_data),
    .pop       (proc_rx_rden),
    .pop_data  (proc_rx_data),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count)
  );

  byte_fifo #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) tx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (proc_tx_wren),
    .push_data (proc_tx_data),
    .pop       (host_tx_ready),
    .pop_data  (host_tx_data),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  assign proc_rx_valid = !rx_empty;
  assign host_rx_ready = !rx_full;
  assign proc_tx_ready = !tx_full;
  assign host_tx_valid = !tx_empty;

  // A new violation in the same cycle as err_clear must not be lost,
  // so the set term takes priority over the clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_rx_underflow <= 1'b0;
      err_tx_overflow  <= 1'b0;
    end else begin
      if (proc_rx_rden && rx_empty) begin
        err_rx_underflow <= 1'b1;
      end else if (err_clear) begin
        err_rx_underflow <= 1'b0;
      end
      if (proc_tx_wren && tx_full) begin
        err_tx_overflow <= 1'b1;
      end else if (err_clear) begin
        err_tx_overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_fifo_bridge.sv
// tb/tb_serial_fifo_bridge.sv - directed self-checking bench for serial_fifo_bridge
module tb_serial_fifo_bridge;

  logic       clock;
  logic       reset;
  logic [7:0] proc_rx_data;
  logic       proc_rx_valid;
  logic       proc_rx_rden;
  logic [7:0] proc_tx_data;
  logic       proc_tx_wren;
  logic       proc_tx_ready;
  logic [7:0] host_rx_data;
  logic       host_rx_valid;
  logic       host_rx_ready;
  logic [7:0] host_tx_data;
  logic       host_tx_valid;
  logic       host_tx_ready;
  logic [4:0] rx_count;
  logic [4:0] tx_count;
  logic       err_rx_underflow;
  logic       err_tx_overflow;
  logic       err_clear;

  int n_assert = 0;
  int n_fail   = 0;

  serial_fifo_bridge dut (
    .clock            (clock),
    .reset            (reset),
    .proc_rx_data     (proc_rx_data),
    .proc_rx_valid    (proc_rx_valid),
    .proc_rx_rden     (proc_rx_rden),
    .proc_tx_data     (proc_tx_data),
    .proc_tx_wren     (proc_tx_wren),
    .proc_tx_ready    (proc_tx_ready),
    .host_rx_data     (host_rx_data),
    .host_rx_valid    (host_rx_valid),
    .host_rx_ready    (host_rx_ready),
    .host_tx_data     (host_tx_data),
    .host_tx_valid    (host_tx_valid),
    .host_tx_ready    (host_tx_ready),
    .rx_count         (rx_count),
    .tx_count         (tx_count),
    .err_rx_underflow (err_rx_underflow),
    .err_tx_overflow  (err_tx_overflow),
    .err_clear        (err_clear)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [7:0] exp_byte;

    reset         = 1'b0;
    proc_rx_rden  = 1'b0;
    proc_tx_data  = 8'h00;
    proc_tx_wren  = 1'b0;
    host_rx_data  = 8'h00;
    host_rx_valid = 1'b0;
    host_tx_ready = 1'b0;
    err_clear     = 1'b0;

    tick();
    tick();
    chk("reset_rx_data", proc_rx_data, 8'h00);
    chk("reset_tx_data", host_tx_data, 8'h00);
    reset = 1'b1;

    // Idle after reset
    repeat (5) tick();
    chk("idle_rx_valid", proc_rx_valid, 1'b0);
    chk("idle_tx_valid", host_tx_valid, 1'b0);
    chk("idle_tx_ready", proc_tx_ready, 1'b1);
    chk("idle_rx_ready", host_rx_ready, 1'b1);
    chk("idle_rx_count", rx_count, 5'd0);
    chk("idle_tx_count", tx_count, 5'd0);
    chk("idle_err_uf", err_rx_underflow, 1'b0);
    chk("idle_err_of", err_tx_overflow, 1'b0);

    // RX: three host bytes, processor pops starting two cycles after the first
    host_rx_valid = 1'b1;
    host_rx_data  = 8'h41;
    tick();
    chk("rx3_cnt1", rx_count, 5'd1);
    chk("rx3_head1", proc_rx_data, 8'h41);
    host_rx_data = 8'h42;
    tick();
    chk("rx3_cnt2", rx_count, 5'd2);
    chk("rx3_d41", proc_rx_data, 8'h41);
    host_rx_data = 8'h43;
    proc_rx_rden = 1'b1;
    tick();
    chk("rx3_cnt_peak", rx_count, 5'd2);
    chk("rx3_d42", proc_rx_data, 8'h42);
    chk("rx3_ready", host_rx_ready, 1'b1);
    host_rx_valid = 1'b0;
    tick();
    chk("rx3_cnt3", rx_count, 5'd1);
    chk("rx3_d43", proc_rx_data, 8'h43);
    tick();
    proc_rx_rden = 1'b0;
    chk("rx3_empty", proc_rx_valid, 1'b0);
    chk("rx3_cnt0", rx_count, 5'd0);
    chk("rx3_no_err", err_rx_underflow, 1'b0);

    // TX: fill to 16 with host stalled, then one overflowing write
    proc_tx_wren = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("tx_fill_ready", proc_tx_ready, 1'b1);
      proc_tx_data = 8'(i);
      tick();
    end
    chk("tx_full_ready", proc_tx_ready, 1'b0);
    chk("tx_full_cnt", tx_count, 5'd16);
    proc_tx_data = 8'hFF;
    tick();
    chk("tx_of_flag", err_tx_overflow, 1'b1);
    chk("tx_of_cnt", tx_count, 5'd16);
    chk("tx_of_head", host_tx_data, 8'h00);

    // Full with simultaneous host pop and processor write: write refused
    host_tx_ready = 1'b1;
    proc_tx_data  = 8'hEE;
    tick();
    proc_tx_wren = 1'b0;
    chk("tx_sim_cnt", tx_count, 5'd15);
    chk("tx_sim_ready", proc_tx_ready, 1'b1);

    // Drain the remainder: must be 0x01..0x0F only
    for (int i = 1; i < 16; i++) begin
      chk("tx_drain_valid", host_tx_valid, 1'b1);
      chk("tx_drain_data", host_tx_data, 32'(i));
      tick();
    end
    host_tx_ready = 1'b0;
    chk("tx_drained_valid", host_tx_valid, 1'b0);
    chk("tx_drained_cnt", tx_count, 5'd0);

    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("tx_of_cleared", err_tx_overflow, 1'b0);

    // Set wins over clear in the same cycle
    err_clear    = 1'b1;
    proc_rx_rden = 1'b1;
    tick();
    proc_rx_rden = 1'b0;
    chk("set_beats_clear", err_rx_underflow, 1'b1);
    tick();
    err_clear = 1'b0;
    chk("uf_cleared", err_rx_underflow, 1'b0);

    // RX wrap: 12 in, 10 out, 8 in, 10 out (20 bytes, pointers wrap)
    host_rx_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      host_rx_data = 8'h60 + 8'(i);
      tick();
    end
    host_rx_valid = 1'b0;
    chk("wrap_cnt12", rx_count, 5'd12);
    exp_byte     = 8'h60;
    proc_rx_rden = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("wrap_data_a", proc_rx_data, exp_byte);
      exp_byte = exp_byte + 8'd1;
      tick();
    end
    proc_rx_rden  = 1'b0;
    host_rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      host_rx_data = 8'h6C + 8'(i);
      tick();
    end
    host_rx_valid = 1'b0;
    chk("wrap_cnt10", rx_count, 5'd10);
    proc_rx_rden = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("wrap_data_b", proc_rx_data, exp_byte);
      exp_byte = exp_byte + 8'd1;
      tick();
    end
    chk("wrap_empty", proc_rx_valid, 1'b0);
    chk("wrap_no_uf", err_rx_underflow, 1'b0);
    tick();
    proc_rx_rden = 1'b0;
    chk("wrap_uf_set", err_rx_underflow, 1'b1);
    chk("wrap_uf_cnt", rx_count, 5'd0);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("wrap_uf_clear", err_rx_underflow, 1'b0);

    // Asynchronous reset mid-burst
    host_rx_valid = 1'b1;
    proc_tx_wren  = 1'b1;
    host_rx_data  = 8'h11;
    proc_tx_data  = 8'h21;
    tick();
    host_rx_data = 8'h12;
    proc_tx_data = 8'h22;
    tick();
    chk("pre_rst_rx_cnt", rx_count, 5'd2);
    chk("pre_rst_tx_cnt", tx_count, 5'd2);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rx_cnt", rx_count, 5'd0);
    chk("async_tx_cnt", tx_count, 5'd0);
    chk("async_rx_valid", proc_rx_valid, 1'b0);
    chk("async_tx_valid", host_tx_valid, 1'b0);
    tick();
    chk("held_rst_rx_cnt", rx_count, 5'd0);
    proc_tx_wren  = 1'b0;
    host_rx_valid = 1'b0;
    reset         = 1'b1;
    host_rx_valid = 1'b1;
    host_rx_data  = 8'h5A;
    tick();
    host_rx_valid = 1'b0;
    chk("post_rst_valid", proc_rx_valid, 1'b1);
    chk("post_rst_data", proc_rx_data, 8'h5A);
    chk("post_rst_cnt", rx_count, 5'd1);
    chk("post_rst_tx_cnt", tx_count, 5'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_fifo_bridge.md
Name: serial_fifo_bridge

Overview:
- Buffers the processor's serial IO port and sits directly between data_memory's serial pins and an external byte-stream host (UART core or testbench).
- RX FIFO: host bytes in, presented to the processor as serial_in/serial_valid_in; popped by serial_rden_out.
- TX FIFO: processor writes via serial_out/serial_wren_out, gated by serial_ready_in; drained by the host with a valid/ready handshake.
- Sticky error flags capture protocol violations on the processor side.

Parameters:
- DATA_W, 8, byte width of both FIFOs.
- DEPTH_LOG2, 4, log2 of entries per FIFO (default 16 entries).

Ports:
- clock  input  1  single clock for all state.
- reset  input  1  asynchronous, active-low; low clears all state immediately.
- proc_rx_data  output  DATA_W  RX FIFO head byte; connects to processor serial_in.
- proc_rx_valid  output  1  RX FIFO non-empty; connects to serial_valid_in.
- proc_rx_rden  input  1  pop RX head; driven by serial_rden_out.
- proc_tx_data  input  DATA_W  byte to send; driven by serial_out.
- proc_tx_wren  input  1  push TX byte; driven by serial_wren_out.
- proc_tx_ready  output  1  TX FIFO not full; connects to serial_ready_in.
- host_rx_data  input  DATA_W  incoming byte from host.
- host_rx_valid  input  1  host offers a byte.
- host_rx_ready  output  1  RX FIFO not full.
- host_tx_data  output  DATA_W  TX FIFO head byte.
- host_tx_valid  output  1  TX FIFO non-empty.
- host_tx_ready  input  1  host accepts the TX head.
- rx_count  output  DEPTH_LOG2+1  RX occupancy.
- tx_count  output  DEPTH_LOG2+1  TX occupancy.
- err_rx_underflow  output  1  sticky: proc_rx_rden asserted while RX was empty.
- err_tx_overflow  output  1  sticky: proc_tx_wren asserted while TX was full.
- err_clear  input  1  synchronous clear of both sticky flags.

Behaviour:
- Reset (reset=0, asynchronous): pointers and counts cleared to 0; all valid outputs 0; proc_tx_ready=1; host_rx_ready=1; data outputs 0; error flags 0. Reset asserted mid-transfer discards all buffered bytes. Nothing is accepted on the edge where reset is released if reset is still low.
- Each FIFO is a circular buffer:
  - Read and write pointers are DEPTH_LOG2 bits and wrap naturally.
  - Count is DEPTH_LOG2+1 bits.
  - full = (count == 2^DEPTH_LOG2); empty = (count == 0).
- Push accepted when push_req && !full. Pop accepted when pop_req && !empty. Both evaluate the pre-edge state.
- Simultaneous accepted push and pop: count unchanged, both pointers advance.
- When full, push is refused even if a pop occurs in the same cycle. ready is a pure register-derived !full, with no combinational path from pop to ready.
- When empty with push and pop together: only the push takes effect; the pop is ignored.
- First-word-fall-through: data output = mem[rd_ptr] whenever valid=1.
  - A byte pushed at edge N is visible with valid=1 after edge N (1-cycle latency).
  - No same-cycle bypass from input to output.
- Data outputs are undefined-but-stable (last mem content) when valid=0; the bench must not check them then.
- RX FIFO: push = host_rx_valid; pop = proc_rx_rden.
- TX FIFO: push = proc_tx_wren; pop = host_tx_ready.
- Error flags:
  - err_rx_underflow sets on any edge with proc_rx_rden=1 && RX empty.
  - err_tx_overflow sets on proc_tx_wren=1 && TX full. The refused byte is dropped and FIFO contents are unchanged.
  - err_clear=1 clears the flags. A set condition in the same cycle as err_clear wins (flag ends set).
- Both FIFOs are independent; activity on one never stalls the other.

Decomposition:
- Shared package: DATA_W default, DEPTH_LOG2 default, and a count-width function (DEPTH_LOG2+1).
- One sub-module, byte_fifo:
  - Parameterised FWFT synchronous FIFO with push/pop/full/empty/count/data.
  - Instantiated twice (rx_fifo, tx_fifo).
- The top adds the sticky error logic and port mapping only.

Test Plan:
- Reset, then idle 5 cycles -> proc_rx_valid=0, host_tx_valid=0, proc_tx_ready=1, host_rx_ready=1, counts=0, flags=0.
- Host pushes 0x41,0x42,0x43 on consecutive cycles; processor pops one per cycle starting 2 cycles later -> proc_rx_data reads 0x41,0x42,0x43 in order; rx_count peaks at 2 (DEPTH_LOG2=4); host_rx_ready stays 1.
- Processor writes 16 bytes 0x00..0x0F with host_tx_ready=0 -> proc_tx_ready=0 after 16th push; a 17th write of 0xFF sets err_tx_overflow and tx_count stays 16. Host then drains and receives exactly 0x00..0x0F with no 0xFF.
- TX full, then host_tx_ready=1 and proc_tx_wren=1 in the same cycle -> the write is refused (ready was 0); tx_count=15 after the edge; next cycle proc_tx_ready=1.
- Push 20 bytes through RX in two bursts so pointers wrap -> data order preserved across the wrap; pop on empty sets err_rx_underflow; err_clear the next cycle clears it.
- Assert reset low mid-burst, asynchronously between edges -> counts and valids drop to 0 immediately; after release, the next pushed byte 0x5A is the first byte read.
